// File: rtl/ccr_unit_pkg.sv
// Shared processor definitions for condition-code handling.
// The branch unit uses the same flag indices and branch encodings.
package ccr_unit_pkg;

  localparam int CCR_W  = 4;
  localparam int FLAG_W = 3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [1:0] {
    BR_JZ  = 2'b00,
    BR_JN  = 2'b01,
    BR_JC  = 2'b10,
    BR_JMP = 2'b11
  } br_type_e;

endpackage

// File: rtl/ccr_shadow_stack.sv
// LIFO of saved condition-code values used across interrupt nesting.
// Pushes on a full stack and pops on an empty stack are ignored here.
module ccr_shadow_stack #(
  parameter int DEPTH = 2,
  parameter int W     = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_r [DEPTH];
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [W-1:0]     dout_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  // A pop takes precedence when both are requested.
  assign pop_ok_s  = pop & ~empty_s;
  assign push_ok_s = push & ~pop & ~full_s;

  // Storage and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (pop_ok_s) begin
      count_r <= count_r - CNT_W'(1);
    end else if (push_ok_s) begin
      count_r <= count_r + CNT_W'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (count_r == CNT_W'(i)) begin
          mem_r[i] <= din;
        end
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Top-of-stack read; zero when empty.
  always_comb begin
    dout_s = {W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      dout_s = (count_r == CNT_W'(i + 1)) ? mem_r[i] : dout_s;
    end
  end

  assign dout  = dout_s;
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/ccr_unit.sv
// Condition code register with branch-driven flag clearing and a
// shadow stack that saves/restores the CCR across interrupts.
module ccr_unit
  import ccr_unit_pkg::*;
#(
  parameter int SHADOW_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [2:0]       alu_flags,
  input  logic [2:0]       flag_we,
  input  logic             setc,
  input  logic             clrc,
  input  logic             br_taken,
  input  logic [1:0]       br_type,
  input  logic             int_save,
  input  logic             rti_restore,
  output logic [CCR_W-1:0] ccr,
  output logic             shadow_ovf,
  output logic             shadow_unf
);

  localparam int CNT_W = $clog2(SHADOW_DEPTH + 1);

  logic [FLAG_W-1:0] flags_r;
  logic              shadow_ovf_r;
  logic              shadow_unf_r;

  logic [FLAG_W-1:0] flags_next_s;
  logic [FLAG_W-1:0] tested_mask_s;
  logic [FLAG_W-1:0] alu_masked_s;
  logic              br_clear_s;
  logic              restore_s;
  logic              underflow_s;
  logic              push_s;
  logic              ovf_set_s;
  logic [FLAG_W-1:0] stack_dout_s;
  logic [CNT_W-1:0]  stack_count_s;
  logic              stack_full_s;
  logic              stack_empty_s;

  // Restore wins over save; stall suppresses every stack request.
  assign restore_s   = rti_restore & ~stall & ~stack_empty_s;
  assign underflow_s = rti_restore & ~stall & (stack_count_s == {CNT_W{1'b0}});
  assign push_s      = int_save & ~stall & ~rti_restore;
  assign ovf_set_s   = push_s & stack_full_s;
  assign br_clear_s  = (tested_mask_s != {FLAG_W{1'b0}});

  assign alu_masked_s = (flags_r & ~flag_we) | (alu_flags & flag_we);

  // Flag tested by a taken conditional branch; JMP tests nothing.
  always_comb begin
    tested_mask_s = {FLAG_W{1'b0}};
    if (br_taken) begin
      case (br_type_e'(br_type))
        BR_JZ:   tested_mask_s[FLAG_Z] = 1'b1;
        BR_JN:   tested_mask_s[FLAG_N] = 1'b1;
        BR_JC:   tested_mask_s[FLAG_C] = 1'b1;
        BR_JMP:  tested_mask_s = {FLAG_W{1'b0}};
        default: tested_mask_s = {FLAG_W{1'b0}};
      endcase
    end else begin
      tested_mask_s = {FLAG_W{1'b0}};
    end
  end

  // Single highest-priority source selects the next flag value.
  always_comb begin
    flags_next_s = flags_r;
    if (stall) begin
      flags_next_s = flags_r;
    end else if (restore_s) begin
      flags_next_s = stack_dout_s;
    end else if (underflow_s) begin
      flags_next_s = flags_r;
    end else if (br_clear_s) begin
      flags_next_s = alu_masked_s & ~tested_mask_s;
    end else if (setc | clrc) begin
      flags_next_s         = flags_r;
      flags_next_s[FLAG_C] = ~clrc;
    end else begin
      flags_next_s = alu_masked_s;
    end
  end

  // Architectural state and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r      <= {FLAG_W{1'b0}};
      shadow_ovf_r <= 1'b0;
      shadow_unf_r <= 1'b0;
    end else if (stall) begin
      flags_r      <= flags_r;
      shadow_ovf_r <= shadow_ovf_r;
      shadow_unf_r <= 1'b0;
    end else begin
      flags_r      <= flags_next_s;
      shadow_ovf_r <= shadow_ovf_r | ovf_set_s;
      shadow_unf_r <= underflow_s;
    end
  end

  // The saved value is the one ccr will show after this edge.
  ccr_shadow_stack #(
    .DEPTH (SHADOW_DEPTH),
    .W     (FLAG_W)
  ) u_shadow_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (restore_s),
    .din   (flags_next_s),
    .dout  (stack_dout_s),
    .count (stack_count_s),
    .full  (stack_full_s),
    .empty (stack_empty_s)
  );

  assign ccr        = {1'b0, flags_r};
  assign shadow_ovf = shadow_ovf_r;
  assign shadow_unf = shadow_unf_r;

endmodule
